risc_ctrl_unit: RTL and testbench

//   Multi-cycle fetch/decode/control FSM directly upstream of registerfile + alu.

---
 rtl/risc_pkg.sv | 41 ++++
 rtl/risc_op_decode.sv | 24 ++
 rtl/risc_ctrl_unit.sv | 124 ++++++++++++
 tb/tb_risc_ctrl_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared constants, opcode/ALU encodings, FSM states and decode payload for the RISC controller.
package risc_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned OPW  = 4;
  localparam int unsigned ALUW = 3;

  localparam logic [OPW-1:0] OP_AND  = 4'h0;
  localparam logic [OPW-1:0] OP_OR   = 4'h1;
  localparam logic [OPW-1:0] OP_ADD  = 4'h2;
  localparam logic [OPW-1:0] OP_SUB  = 4'h3;
  localparam logic [OPW-1:0] OP_ADC  = 4'h4;
  localparam logic [OPW-1:0] OP_CMP  = 4'h7;
  localparam logic [OPW-1:0] OP_LDI  = 4'h8;
  localparam logic [OPW-1:0] OP_HALT = 4'hF;

  localparam logic [ALUW-1:0] ALU_AND = 3'd0;
  localparam logic [ALUW-1:0] ALU_OR  = 3'd1;
  localparam logic [ALUW-1:0] ALU_ADD = 3'd2;
  localparam logic [ALUW-1:0] ALU_SUB = 3'd3;
  localparam logic [ALUW-1:0] ALU_CMP = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [ALUW-1:0] alu_c;
    logic            use_carry;
    logic            writes_reg;
    logic            is_ldi;
    logic            is_halt;
    logic            is_illegal;
  } dec_t;

endpackage

// File: rtl/risc_op_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode onto ALU control and instruction class.
module risc_op_decode
  import risc_pkg::*;
(
  input  logic [OPW-1:0] op,
  output dec_t           dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_AND:  begin dec.alu_c = ALU_AND; dec.writes_reg = 1'b1; end
      OP_OR:   begin dec.alu_c = ALU_OR;  dec.writes_reg = 1'b1; end
      OP_ADD:  begin dec.alu_c = ALU_ADD; dec.writes_reg = 1'b1; end
      OP_SUB:  begin dec.alu_c = ALU_SUB; dec.writes_reg = 1'b1; end
      OP_ADC:  begin dec.alu_c = ALU_ADD; dec.writes_reg = 1'b1; dec.use_carry = 1'b1; end
      OP_CMP:  dec.alu_c = ALU_CMP;
      OP_LDI:  begin dec.is_ldi = 1'b1; dec.writes_reg = 1'b1; end
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller driving an external register file and ALU.
module risc_ctrl_unit
  import risc_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic [DW-1:0]   instruction,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [AW-1:0]   Aaddr,
  output logic [AW-1:0]   Baddr,
  output logic [AW-1:0]   Caddr,
  output logic [DW-1:0]   C,
  output logic            load,
  output logic [ALUW-1:0] alu_c,
  output logic            alu_cin,
  input  logic [DW-1:0]   alu_z,
  input  logic            alu_cout,
  input  logic            alu_lt,
  input  logic            alu_eq,
  input  logic            alu_gt,
  output logic            carry,
  output logic            lt,
  output logic            eq,
  output logic            gt,
  output logic            illegal,
  output logic            halted
);

  state_t         state;
  logic [DW-1:0]  ir;
  logic [OPW-1:0] op_sel;
  dec_t           dec;

  // In FETCH the ALU controls must come from the incoming word; afterwards from the IR.
  assign op_sel = (state == ST_FETCH) ? instruction[DW-1:DW-OPW] : ir[DW-1:DW-OPW];

  risc_op_decode u_dec (
    .op  (op_sel),
    .dec (dec)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= ST_FETCH;
      ir          <= '0;
      instr_ready <= 1'b1;
      Aaddr       <= '0;
      Baddr       <= '0;
      Caddr       <= '0;
      C           <= '0;
      load        <= 1'b0;
      alu_c       <= '0;
      alu_cin     <= 1'b0;
      carry       <= 1'b0;
      lt          <= 1'b0;
      eq          <= 1'b0;
      gt          <= 1'b0;
      illegal     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      load    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (instr_valid) begin
            ir          <= instruction;
            Aaddr       <= instruction[11:8];
            Baddr       <= instruction[7:4];
            alu_c       <= dec.alu_c;
            alu_cin     <= dec.use_carry & carry;
            instr_ready <= 1'b0;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec.is_ldi) begin
            C     <= {8'h00, ir[7:0]};
            Caddr <= ir[11:8];
            load  <= 1'b1;
            state <= ST_WB;
          end else if (dec.is_illegal) begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= ST_FETCH;
          end else if (dec.is_halt) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          C     <= alu_z;
          Caddr <= ir[3:0];
          // Only ADD/ADC map onto the adder code, so this gates the carry update.
          if (dec.alu_c == ALU_ADD) carry <= alu_cout;
          if (dec.alu_c == ALU_CMP) begin
            lt <= alu_lt;
            eq <= alu_eq;
            gt <= alu_gt;
          end
          if (dec.writes_reg) begin
            load  <= 1'b1;
            state <= ST_WB;
          end else begin
            instr_ready <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        ST_WB: begin
          instr_ready <= 1'b1;
          state       <= ST_FETCH;
        end
        ST_HALT: ;
        default: begin
          instr_ready <= 1'b1;
          state       <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_ctrl_unit.sv
// Bench for risc_ctrl_unit with register file and ALU models, directed scenarios plus random programs.
`timescale 1ns/1ps
module tb_risc_ctrl_unit;
  import risc_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  Aaddr, Baddr, Caddr;
  logic [15:0] C;
  logic        load;
  logic [2:0]  alu_c;
  logic        alu_cin;
  logic [15:0] alu_z;
  logic        alu_cout, alu_lt, alu_eq, alu_gt;
  logic        carry, lt, eq, gt, illegal, halted;

  risc_ctrl_unit dut (
    .clock(clock), .clear(clear), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Aaddr(Aaddr), .Baddr(Baddr), .Caddr(Caddr), .C(C),
    .load(load), .alu_c(alu_c), .alu_cin(alu_cin), .alu_z(alu_z), .alu_cout(alu_cout),
    .alu_lt(alu_lt), .alu_eq(alu_eq), .alu_gt(alu_gt), .carry(carry), .lt(lt), .eq(eq),
    .gt(gt), .illegal(illegal), .halted(halted)
  );

  initial forever #5 clock = ~clock;

  // Register file: registered read ports, write on load.
  logic [15:0] rf [16];
  logic [15:0] a_q, b_q;
  logic        rf_clear;
  always_ff @(posedge clock) begin
    if (rf_clear) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (load) begin
      rf[Caddr] <= C;
    end
    a_q <= rf[Aaddr];
    b_q <= rf[Baddr];
  end

  // ALU model.
  logic [16:0] sum;
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q} + 17'(alu_cin);
    alu_z    = '0;
    alu_cout = 1'b0;
    case (alu_c)
      3'd0: alu_z = a_q & b_q;
      3'd1: alu_z = a_q | b_q;
      3'd2: begin alu_z = sum[15:0]; alu_cout = sum[16]; end
      3'd3: alu_z = a_q - b_q;
      default: alu_z = '0;
    endcase
    alu_lt = (a_q < b_q);
    alu_eq = (a_q == b_q);
    alu_gt = (a_q > b_q);
  end

  typedef struct packed { logic [3:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q [$];

  int checks = 0, failures = 0;
  int load_cnt = 0, ill_cnt = 0;
  bit prev_load = 1'b0, prev_ill = 1'b0;

  logic [15:0] m_rf [16];
  bit m_c, m_lt, m_eq, m_gt;
  logic [3:0] legal_ops [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8};
  logic [3:0] bad_ops   [6] = '{4'h5, 4'h6, 4'h9, 4'hA, 4'hB, 4'hC};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Architectural reference: executes one instruction on the model state.
  task automatic model_apply(input logic [15:0] ins, output bit wen, output bit ill, output int cyc);
    logic [3:0]  op, a, b, d;
    logic [15:0] va, vb, res;
    int unsigned s;
    op = ins[15:12]; a = ins[11:8]; b = ins[7:4]; d = ins[3:0];
    va = m_rf[a]; vb = m_rf[b];
    wen = 1'b1; ill = 1'b0; cyc = 4; res = '0;
    case (op)
      4'h0: res = va & vb;
      4'h1: res = va | vb;
      4'h2: begin s = 32'(va) + 32'(vb); m_c = (s > 32'd65535); res = 16'(s); end
      4'h3: res = 16'(va - vb);
      4'h4: begin s = 32'(va) + 32'(vb) + 32'(m_c); m_c = (s > 32'd65535); res = 16'(s); end
      4'h7: begin m_lt = va < vb; m_eq = va == vb; m_gt = va > vb; wen = 1'b0; cyc = 3; end
      4'h8: begin d = ins[11:8]; res = {8'h00, ins[7:0]}; cyc = 3; end
      4'hF: begin wen = 1'b0; cyc = 2; end
      default: begin wen = 1'b0; ill = 1'b1; cyc = 2; end
    endcase
    if (wen) begin
      m_rf[d] = res;
      exp_q.push_back('{addr: d, data: res});
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin @(negedge clock); #1; n++; end
    chk("ready_wait", 32'(instr_ready), 32'd1);
  endtask

  task automatic handshake(input logic [15:0] ins);
    wait_ready();
    instruction = ins;
    instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    instruction = 16'($urandom);
  endtask

  task automatic run(input logic [15:0] ins);
    bit wen, ill;
    int cyc, l0, i0, n;
    handshake(ins);
    l0 = load_cnt; i0 = ill_cnt;
    model_apply(ins, wen, ill, cyc);
    n = 0;
    do begin @(negedge clock); n++; end while (!instr_ready && !halted && n < 12);
    #1;
    chk("cycles", 32'(n), 32'(cyc));
    chk("load_count", 32'(load_cnt - l0), 32'(wen));
    chk("illegal_count", 32'(ill_cnt - i0), 32'(ill));
    chk("flags", 32'({carry, lt, eq, gt}), 32'({m_c, m_lt, m_eq, m_gt}));
  endtask

  // Monitor: every load is popped against the scoreboard; pulses must be one cycle wide.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (clear) begin
        prev_load = 1'b0; prev_ill = 1'b0;
      end else begin
        if (load) begin
          load_cnt++;
          chk("load_width", 32'(prev_load), 32'd0);
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_load actual=R%0d<=%h expected=no write", Caddr, C);
          end else begin
            e = exp_q.pop_front();
            chk("wb_addr", 32'(Caddr), 32'(e.addr));
            chk("wb_data", 32'(C), 32'(e.data));
          end
        end
        if (illegal) begin
          ill_cnt++;
          chk("illegal_width", 32'(prev_ill), 32'd0);
        end
        prev_load = load; prev_ill = illegal;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, gap;
    logic [3:0] op;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_c = 0; m_lt = 0; m_eq = 0; m_gt = 0;
    clear = 1'b1; rf_clear = 1'b1; instr_valid = 1'b0; instruction = '0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_ctrl", 32'({load, halted, illegal, carry, lt, eq, gt, alu_cin, alu_c, Aaddr, Baddr, Caddr}), 32'd0);
    chk("reset_C", 32'(C), 32'd0);
    clear = 1'b0; rf_clear = 1'b0;
    @(negedge clock); #1;
    chk("post_reset_ready", 32'(instr_ready), 32'd1);

    // Load and add
    run(16'h810F); run(16'h820B); run(16'h2123);
    chk("t1_r1", 32'(rf[1]), 32'h000F);
    chk("t1_r2", 32'(rf[2]), 32'h000B);
    chk("t1_r3", 32'(rf[3]), 32'h001A);
    chk("t1_carry", 32'(carry), 32'd0);

    // Subtract, carry-out, carry-in
    run(16'h3015); chk("t2_r5", 32'(rf[5]), 32'hFFF1);
    run(16'h2556); chk("t2_r6", 32'(rf[6]), 32'hFFE2); chk("t2_carry", 32'(carry), 32'd1);
    run(16'h4007); chk("t2_r7", 32'(rf[7]), 32'h0001);

    // Compare
    run(16'h7120); chk("t3_gt", 32'({lt, eq, gt}), 32'b001);
    run(16'h7110); chk("t3_eq", 32'({lt, eq, gt}), 32'b010);

    // Illegal opcode (cycle and pulse checks inside run)
    run(16'h5123);

    // Halt: stays parked with valid held high
    run(16'hF000);
    chk("t5_halted", 32'(halted), 32'd1);
    l0 = load_cnt;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instruction = 16'($urandom);
      @(negedge clock); #1;
      chk("t5_halt_hold", 32'({instr_ready, halted}), 32'b01);
    end
    instr_valid = 1'b0;
    chk("t5_no_load", 32'(load_cnt - l0), 32'd0);
    clear = 1'b1;
    @(negedge clock); clear = 1'b0; #1;
    m_c = 0; m_lt = 0; m_eq = 0; m_gt = 0;
    chk("t5_clear", 32'({instr_ready, halted}), 32'b10);

    // Reset during EXEC: aborted, no writeback, flags zeroed
    run(16'h7110);
    handshake(16'h2124);
    @(negedge clock); @(negedge clock); #1;
    l0 = load_cnt;
    clear = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    m_c = 0; m_lt = 0; m_eq = 0; m_gt = 0;
    chk("t6_no_load", 32'(load_cnt - l0), 32'd0);
    chk("t6_r4", 32'(rf[4]), 32'h0000);
    chk("t6_flags", 32'({carry, lt, eq, gt}), 32'd0);
    chk("t6_ready", 32'(instr_ready), 32'd1);
    run(16'h810F);
    chk("t6_r1", 32'(rf[1]), 32'h000F);

    // Random programs
    for (int k = 0; k < 300; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(negedge clock); #1; end
      if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 5)];
      else                            op = legal_ops[$urandom_range(0, 6)];
      run({op, 12'($urandom)});
    end

    for (int i = 0; i < 16; i++) chk($sformatf("final_r%0d", i), 32'(rf[i]), 32'(m_rf[i]));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
